// File: rtl/mips_cpu_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO register pair (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency: mul/div done WIDTH+2 cycles after the accepting edge; mthi/mtlo done one cycle after it.
// Backpressure: start is ignored while busy (no queuing); the CPU stalls HI/LO accesses while busy is high.
module mips_cpu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier bits}. Divide: low half holds dividend shifting into quotient.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;      // restoring-division partial remainder
    logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   dvd_q, dvd_d;      // raw dividend, returned in HI on divide by zero
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d; // product sign, or quotient sign
    logic               neg_hi_q, neg_hi_d; // remainder sign (follows dividend)
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

    // One shift-add step: add multiplicand to the upper half when the current multiplier bit is set.
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    // One restoring step: bring in the next dividend bit and try subtracting the divisor.
    // The shifted remainder is below 2*divisor, so bit WIDTH of the difference is its sign.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign prod_fix  = neg_lo_q ? -acc_q : acc_q;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // State register; reset aborts any operation in flight and clears HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            dvd_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            dvd_q    <= dvd_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    // Next-state, datapath iteration and HI/LO write-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        dvd_d    = dvd_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MTHI: begin
                            hi_d   = a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d   = a;
                            done_d = 1'b1;
                            dbz_d  = 1'b0;
                        end
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {{WIDTH{1'b0}}, mag_b};
                            opnd_d   = mag_a;
                            neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_d = 1'b0;
                            is_div_d = 1'b0;
                            bzero_d  = 1'b0;
                            cnt_d    = CW'(WIDTH - 1);
                            dbz_d    = 1'b0;
                            state_d  = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, mag_a};
                            opnd_d   = mag_b;
                            rem_d    = '0;
                            dvd_d    = a;
                            neg_lo_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_d = is_signed && a[WIDTH-1];
                            is_div_d = 1'b1;
                            bzero_d  = (b == '0);
                            cnt_d    = CW'(WIDTH - 1);
                            dbz_d    = 1'b0;
                            state_d  = S_DIV;
                        end
                        default: ; // unknown function code: ignored entirely
                    endcase
                end
            end
            S_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = S_FINISH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_DIV: begin
                if (!div_diff[WIDTH]) begin
                    rem_d             = div_diff[WIDTH-1:0];
                    acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d             = div_shift[WIDTH-1:0];
                    acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = S_FINISH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_FINISH: begin
                if (is_div_q) begin
                    if (bzero_q) begin
                        lo_d  = '1;
                        hi_d  = dvd_q;
                        dbz_d = 1'b1;
                    end else begin
                        // -2^(W-1) / -1 lands here naturally: magnitude quotient 2^(W-1), positive sign.
                        lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_hi_q ? -rem_q : rem_q;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_cpu_muldiv_unit.sv
// Self-checking bench for mips_cpu_muldiv_unit at WIDTH=32.
// Expected HI/LO/div_by_zero are pushed to a queue when an accepted op is driven and popped on each done.
// Timing, busy and reset behaviour are checked inline by the per-scenario tasks.
module tb_mips_cpu_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic         clk;
    logic         reset;
    logic         start;
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mips_cpu_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .a           (a),
        .b           (b),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model built on native SystemVerilog arithmetic.
    function automatic exp_t model(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [2*W-1:0] p;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.dbz = 1'b0;
        case (o)
            OP_MTHI: e.hi = x;
            OP_MTLO: e.lo = x;
            OP_MULTU: begin
                p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                {e.hi, e.lo} = p;
            end
            OP_MULT: begin
                p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
                {e.hi, e.lo} = p;
            end
            OP_DIVU: begin
                if (y == '0) begin e.lo = '1; e.hi = x; e.dbz = 1'b1; end
                else begin e.lo = x / y; e.hi = x % y; end
            end
            OP_DIV: begin
                if (y == '0) begin e.lo = '1; e.hi = x; e.dbz = 1'b1; end
                else if (x == {1'b1, {(W-1){1'b0}}} && y == '1) begin e.lo = x; e.hi = '0; end
                else begin
                    e.lo = W'($signed(x) / $signed(y));
                    e.hi = W'($signed(x) % $signed(y));
                end
            end
            default: ;
        endcase
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done hi=%h lo=%h with no pending op", hi, lo);
            end else begin
                mon_e = sbq.pop_front();
                if ({hi, lo, div_by_zero} !== {mon_e.hi, mon_e.lo, mon_e.dbz}) begin
                    failures++;
                    $display("FAIL result got hi=%h lo=%h dbz=%b want hi=%h lo=%h dbz=%b",
                             hi, lo, div_by_zero, mon_e.hi, mon_e.lo, mon_e.dbz);
                end
            end
        end
    end

    // Drive one start; sampled at the next rising edge. Returns 1 time unit after that edge.
    task automatic issue(input logic [5:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit accepted);
        exp_t e;
        op = o; a = x; b = y; start = 1'b1;
        if (accepted) begin
            e = model(o, x, y);
            sbq.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count falling edges until done (n), and busy cycles before it (nb). Optionally pulses an mthi start at n==inj_at.
    task automatic wait_done(input int inj_at, output int n, output int nb);
        bit fin;
        n = 0; nb = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            n++;
            start = (n == inj_at);
            if (n == inj_at) begin op = OP_MTHI; a = 32'h0000DEAD; end
            if (done === 1'b1) fin = 1'b1;
            else begin
                if (busy === 1'b1) nb++;
                if (n >= 200) begin
                    checks++; failures++;
                    $display("FAIL done_timeout no done within %0d cycles", n);
                    fin = 1'b1;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b want=000", {busy, done, div_by_zero});
        end
        checks++;
        if ({hi, lo} !== {(2*W){1'b0}}) begin
            failures++; $display("FAIL reset_hilo got hi=%h lo=%h want 0", hi, lo);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int n, nb;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        wait_done(-1, n, nb);
        checks++;
        if (n !== 34) begin failures++; $display("FAIL multu_latency got=%0d want=34", n); end
        checks++;
        if (nb !== 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d want=33", nb); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_at_done got=%b want=0", busy); end
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
            failures++; $display("FAIL multu_value got=%h%h want=FFFFFFFE00000001", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL done_single_pulse got=%b want=0", done); end
    endtask

    task automatic test_mult();
        int n, nb;
        issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007, 1'b1);
        wait_done(-1, n, nb);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            failures++; $display("FAIL mult_neg got=%h%h want=FFFFFFFFFFFFFFEB", hi, lo);
        end
        issue(OP_MULT, 32'h80000000, 32'h80000000, 1'b1);
        wait_done(-1, n, nb);
        checks++;
        if ({hi, lo} !== 64'h40000000_00000000) begin
            failures++; $display("FAIL mult_min got=%h%h want=4000000000000000", hi, lo);
        end
        // a few extra mixed-sign products through the scoreboard
        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? OP_MULT : OP_MULTU, $urandom, $urandom, 1'b1);
            wait_done(-1, n, nb);
        end
    endtask

    task automatic test_div();
        int n, nb;
        issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002, 1'b1);
        wait_done(-1, n, nb);
        checks++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            failures++; $display("FAIL div_neg got hi=%h lo=%h want hi=FFFFFFFF lo=FFFFFFFD", hi, lo);
        end
        issue(OP_DIVU, 32'h00000007, 32'h00000000, 1'b1);
        wait_done(-1, n, nb);
        checks++;
        if (n !== 34) begin failures++; $display("FAIL div0_latency got=%0d want=34", n); end
        checks++;
        if ({div_by_zero, hi, lo} !== {1'b1, 32'h00000007, 32'hFFFFFFFF}) begin
            failures++; $display("FAIL div0_value got dbz=%b hi=%h lo=%h want dbz=1 hi=7 lo=FFFFFFFF",
                                 div_by_zero, hi, lo);
        end
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_hold got=%b want=1", div_by_zero); end
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        checks++;
        if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_clear got=%b want=0", div_by_zero); end
        wait_done(-1, n, nb);
        checks++;
        if ({div_by_zero, hi, lo} !== {1'b0, 32'h00000000, 32'h80000000}) begin
            failures++; $display("FAIL div_ovf got dbz=%b hi=%h lo=%h want dbz=0 hi=0 lo=80000000",
                                 div_by_zero, hi, lo);
        end
        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? OP_DIV : OP_DIVU, $urandom, $urandom_range(1, 50000), 1'b1);
            wait_done(-1, n, nb);
        end
    endtask

    task automatic test_mthi_mtlo();
        issue(OP_MTHI, 32'h12345678, 32'h0, 1'b1);
        checks++;
        if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_value got=%h want=12345678", hi); end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL mthi_done got done,busy=%b want=10", {done, busy}); end
        issue(OP_MTLO, 32'h9ABCDEF0, 32'h0, 1'b1);
        checks++;
        if ({hi, lo} !== 64'h12345678_9ABCDEF0) begin
            failures++; $display("FAIL mtlo_value got hi=%h lo=%h want 12345678 9ABCDEF0", hi, lo);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL mtlo_done got done,busy=%b want=10", {done, busy}); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL mtlo_single_pulse got=%b want=0", done); end
    endtask

    task automatic test_back_to_back();
        int n, nb;
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_done(5, n, nb);
        checks++;
        if (n !== 34) begin failures++; $display("FAIL busy_ignore_latency got=%0d want=34", n); end
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            failures++; $display("FAIL busy_ignore_value got hi=%h lo=%h want hi=2 lo=E", hi, lo);
        end
        // start issued in the done cycle is accepted
        issue(OP_MTLO, 32'h000055AA, 32'h0, 1'b1);
        checks++;
        if (lo !== 32'h000055AA) begin failures++; $display("FAIL done_cycle_start got=%h want=55AA", lo); end
        @(negedge clk);
        issue(OP_MULTU, 32'd3, 32'd5, 1'b1);
        wait_done(-1, n, nb);
        checks++;
        if (n !== 34) begin failures++; $display("FAIL b2b_mul_latency got=%0d want=34", n); end
    endtask

    task automatic test_undefined_op();
        int seen;
        seen = 0;
        issue(6'b100000, 32'hAAAA5555, 32'h1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            if (busy === 1'b1 || done === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL undef_op_activity got=%0d want=0", seen); end
        checks++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            failures++; $display("FAIL undef_op_hold got hi=%h lo=%h want hi=%h lo=%h", hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        issue(OP_MULTU, 32'h00012345, 32'h00006789, 1'b1);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== {2'b00, {(2*W){1'b0}}}) begin
            failures++; $display("FAIL reset_abort got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL reset_no_done got=%0d want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_back_to_back();
        test_undefined_op();
        test_reset_abort();
        repeat (2) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL pending_results got=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv_unit.md
Name: mips_cpu_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit owning the HI/LO register pair for the MIPS CPU. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. A start/busy/done handshake lets the pipeline stall MFHI/MFLO and further HI/LO ops until results are valid. Multiply and divide are multi-cycle radix-2 iterations, with sign handling for the signed variants.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (>=4, even)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
op  input  6  function code: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo
a  input  WIDTH  rs operand / dividend / multiplicand / mthi-mtlo source
b  input  WIDTH  rt operand / divisor / multiplier
start  input  1  request; sampled on rising clk edge when not busy
busy  output  1  operation in progress; CPU stalls HI/LO accesses while high
done  output  1  one-cycle pulse: hi/lo hold the new result this cycle
div_by_zero  output  1  set with done when a div/divu had b==0; cleared at next accepted start
hi  output  WIDTH  architectural HI register
lo  output  WIDTH  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, iteration counter=0. Reset mid-operation aborts the op; no done pulse follows.
- FSM states: IDLE, MUL, DIV, FINISH.
- IDLE: start=1 with a valid op is accepted at that edge (cycle k).
  - mthi/mtlo: hi (or lo) <= a at edge k. done=1 in cycle k+1. busy stays 0.
  - mult/multu: latch |a|, |b| (signed) or a, b (unsigned). Latch result sign = a[W-1]^b[W-1] (signed only). Go to MUL.
  - div/divu: same magnitude latch. Quotient sign = a[W-1]^b[W-1]. Remainder sign = a[W-1]. Go to DIV.
  - Undefined op with start: ignored, no state change, no done.
- MUL: WIDTH iterations of shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle. Counter runs WIDTH-1 down to 0, then FINISH.
- DIV: WIDTH iterations of restoring division, one quotient bit per cycle, WIDTH+1-bit partial remainder. Then FINISH.
- FINISH (one cycle): apply sign correction (two's complement negate) and write hi/lo at the exiting edge.
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
- Timing: busy=1 in cycles k+1..k+WIDTH+1. done=1 and busy=0 in cycle k+WIDTH+2. Latency to done is WIDTH+2 cycles for all mul/div ops.
- Divide by zero: runs the same latency, then lo = all ones, hi = a (unmodified dividend), div_by_zero=1.
- Signed overflow (-2^(W-1) / -1): lo = 0x80..0, hi = 0, div_by_zero=0.
- start while busy=1: ignored, no queuing.
- start in the done cycle: accepted, since the FSM is back in IDLE.
- hi/lo change only at a FINISH exit or an mthi/mtlo edge. Otherwise they hold their values, including across ignored starts.
- done is never asserted for two consecutive cycles without an intervening accepted start.

Test Plan:
- Reset: pulse reset=0 mid-multu at iteration 10 -> busy=0, hi=lo=0 immediately; no done pulse in the following 40 cycles.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) -> done exactly 34 cycles after start, hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- mult a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_by_zero=1. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 back-to-back -> hi, lo updated one edge after each start, done each following cycle, busy never high.
- divu a=100, b=7 started, then start with mthi a=0xDEAD at cycle +5 -> mthi ignored; done at cycle +34 with lo=14, hi=2. A start in the done cycle is accepted.
